change_dispenser: RTL

Downstream of the purchase controller: takes the change amount it computes at the end of a purchase or on cancel, and pays it out. Coins are released one at a time through a request/acknowledge handshake with the coin hopper, largest available coin first. Reports remaining balance, shortfall when the hopper cannot cover the amount, and optionally a hopper timeout fault.

---
 rtl/change_dispenser.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time, largest
// available coin first, over a req/ack handshake with the coin hopper.
// Optional hopper timeout fault is compiled in with `define CHG_TIMEOUT_EN.
module change_dispenser #(
   parameter int AMT_W       = 10,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic [3:0]       empty,
   input  logic             coin_ack,
   output logic             coin_req,
   output logic [1:0]       coin_sel,
   output logic             busy,
   output logic             done,
   output logic [AMT_W-1:0] remaining,
   output logic             shortfall,
   output logic             fault
);

   typedef enum logic [1:0] {IDLE, SELECT, REQ, DONE} state_t;

   state_t           state;
   logic             pick_ok;
   logic [1:0]       pick_sel;

   // Amount widths below 7 bits cannot hold a dollar; the timeout needs at least one cycle.
   if (AMT_W < 7 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("change_dispenser: AMT_W must be >= 7 and TIMEOUT_CYC >= 1");
   end

   // Face value in cents of each coin_sel code.
   function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] sel);
      case (sel)
         2'b00:   coin_value = AMT_W'(5);
         2'b01:   coin_value = AMT_W'(10);
         2'b10:   coin_value = AMT_W'(25);
         default: coin_value = AMT_W'(100);
      endcase
   endfunction

`ifdef CHG_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] tmo_cnt;
`else
   assign fault = 1'b0;
`endif

   // Largest coin that fits in the balance and whose tube still has coins.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      pick_ok  = 1'b1;
      pick_sel = 2'b11;
      if (!empty[3] && remaining >= coin_value(2'b11))      pick_sel = 2'b11;
      else if (!empty[2] && remaining >= coin_value(2'b10)) pick_sel = 2'b10;
      else if (!empty[1] && remaining >= coin_value(2'b01)) pick_sel = 2'b01;
      else if (!empty[0] && remaining >= coin_value(2'b00)) pick_sel = 2'b00;
      else                                                  pick_ok  = 1'b0;
   end

   // Payout FSM; all outputs are registered here.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees pre-edge values regardless of statement order.
      if (rst) begin
         state     <= IDLE;
         coin_req  <= 1'b0;
         coin_sel  <= 2'b00;
         busy      <= 1'b0;
         done      <= 1'b0;
         remaining <= '0;
         shortfall <= 1'b0;
`ifdef CHG_TIMEOUT_EN
         fault     <= 1'b0;
         tmo_cnt   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  remaining <= amount;
                  shortfall <= 1'b0;
`ifdef CHG_TIMEOUT_EN
                  fault     <= 1'b0;
`endif
                  busy      <= 1'b1;
                  state     <= SELECT;
               end
            end
            SELECT: begin
               if (remaining == '0) begin
                  state <= DONE;
               end else if (pick_ok) begin
                  coin_sel <= pick_sel;
                  coin_req <= 1'b1;
`ifdef CHG_TIMEOUT_EN
                  tmo_cnt  <= '0;
`endif
                  state    <= REQ;
               end else begin
                  shortfall <= 1'b1;
                  state     <= DONE;
               end
            end
            REQ: begin
               if (coin_ack) begin
                  // coin_sel was chosen with value <= remaining, so no underflow.
                  remaining <= remaining - coin_value(coin_sel);
                  coin_req  <= 1'b0;
                  state     <= SELECT;
               end
`ifdef CHG_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  // Timed-out coin is not counted as paid.
                  fault     <= 1'b1;
                  shortfall <= 1'b1;
                  coin_req  <= 1'b0;
                  state     <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               // First cycle raises done; second drops done and busy together.
               if (!done) begin
                  done <= 1'b1;
               end else begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
